// File: rtl/bcd_time_setter.sv
// Key-driven editor for the 12-hour BCD clock: debounces three keys,
// steps through hh/mm/ss/pm fields and commits with a one-cycle load.
module bcd_time_setter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    input  logic       cur_pm,
    output logic [7:0] set_hh,
    output logic [7:0] set_mm,
    output logic [7:0] set_ss,
    output logic       set_pm,
    output logic       load,
    output logic       set_active,
    output logic [1:0] field
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_HH,
        S_EDIT_MM,
        S_EDIT_SS,
        S_EDIT_PM,
        S_COMMIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2:0]      w_raw;
    logic [2:0]      r_s1;
    logic [2:0]      r_s2;
    logic [2:0]      r_acc;
    logic [2:0]      r_acc_d;
    logic [2:0]      r_ev;
    logic [DW-1:0]   r_db_cnt [3];

    logic [TW-1:0]   r_to;
    logic            w_timeout;
    logic            w_any_ev;
    logic            w_ev_mode;
    logic            w_ev_inc;
    logic            w_ev_dec;
    logic            w_step;

    logic [7:0]      r_hh;
    logic [7:0]      r_mm;
    logic [7:0]      r_ss;
    logic            r_pm;

    function automatic logic hh_ok(input logic [7:0] v);
        return (v[7:4] == 4'd0 && v[3:0] >= 4'd1 && v[3:0] <= 4'd9) ||
               (v[7:4] == 4'd1 && v[3:0] <= 4'd2);
    endfunction

    function automatic logic sx_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] hh_inc(input logic [7:0] v);
        if (v == 8'h12)
            return 8'h01;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hh_dec(input logic [7:0] v);
        if (v == 8'h01)
            return 8'h12;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] sx_inc(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] sx_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h59;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_raw     = {key_dec, key_inc, key_mode};
    assign w_ev_mode = r_ev[0];
    assign w_ev_inc  = r_ev[1] & ~r_ev[2];
    assign w_ev_dec  = r_ev[2] & ~r_ev[1];
    assign w_step    = (w_ev_inc | w_ev_dec) & ~w_ev_mode;
    assign w_any_ev  = |r_ev;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_to == TO_LAST);

    // Synchronise, debounce and edge-detect the three keys
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_acc   <= '0;
            r_acc_d <= '0;
            r_ev    <= '0;
            for (int k = 0; k < 3; k++)
                r_db_cnt[k] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_acc_d <= r_acc;
            r_ev    <= r_acc & ~r_acc_d;
            for (int k = 0; k < 3; k++) begin
                if (r_s2[k] == r_acc[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_acc[k]    <= r_s2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DW'(1);
                end
            end
        end
    end

    // Idle counter for edit abandonment, saturating at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_to <= '0;
        else if (!set_active || w_any_ev)
            r_to <= '0;
        else if (r_to != TO_LAST)
            r_to <= r_to + TW'(1);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        load        = 1'b0;
        set_active  = 1'b0;
        field       = 2'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ev_mode)
                    w_state_nxt = S_EDIT_HH;
            end
            S_EDIT_HH: begin
                set_active = 1'b1;
                field      = 2'd0;
                if (w_ev_mode)
                    w_state_nxt = S_EDIT_MM;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_EDIT_MM: begin
                set_active = 1'b1;
                field      = 2'd1;
                if (w_ev_mode)
                    w_state_nxt = S_EDIT_SS;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_EDIT_SS: begin
                set_active = 1'b1;
                field      = 2'd2;
                if (w_ev_mode)
                    w_state_nxt = S_EDIT_PM;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_EDIT_PM: begin
                set_active = 1'b1;
                field      = 2'd3;
                if (w_ev_mode)
                    w_state_nxt = S_COMMIT;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_COMMIT: begin
                load        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shadow time: capture with normalisation, then per-field BCD stepping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hh <= 8'h12;
            r_mm <= 8'h00;
            r_ss <= 8'h00;
            r_pm <= 1'b0;
        end else if (r_state == S_IDLE && w_ev_mode) begin
            r_hh <= hh_ok(cur_hh) ? cur_hh : 8'h12;
            r_mm <= sx_ok(cur_mm) ? cur_mm : 8'h00;
            r_ss <= sx_ok(cur_ss) ? cur_ss : 8'h00;
            r_pm <= cur_pm;
        end else if (w_step) begin
            unique case (r_state)
                S_EDIT_HH: r_hh <= w_ev_inc ? hh_inc(r_hh) : hh_dec(r_hh);
                S_EDIT_MM: r_mm <= w_ev_inc ? sx_inc(r_mm) : sx_dec(r_mm);
                S_EDIT_SS: r_ss <= w_ev_inc ? sx_inc(r_ss) : sx_dec(r_ss);
                S_EDIT_PM: r_pm <= ~r_pm;
                default: ;
            endcase
        end
    end

    assign set_hh = r_hh;
    assign set_mm = r_mm;
    assign set_ss = r_ss;
    assign set_pm = r_pm;

endmodule

// File: tb/tb_bcd_time_setter.sv
// Directed bench for bcd_time_setter: key timing, field stepping,
// commit strobe, glitch rejection, timeout and reset abandonment.
module tb_bcd_time_setter;

    localparam int D = 4;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_mode, key_inc, key_dec;
    logic [7:0] cur_hh, cur_mm, cur_ss;
    logic       cur_pm;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_pm, load, set_active;
    logic [1:0] field;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_loads  = 0;
    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic       ld_pm;

    bcd_time_setter #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .cur_hh    (cur_hh),
        .cur_mm    (cur_mm),
        .cur_ss    (cur_ss),
        .cur_pm    (cur_pm),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .set_pm    (set_pm),
        .load      (load),
        .set_active(set_active),
        .field     (field)
    );

    always #5 clk = ~clk;

    // Count load strobes and latch the committed time
    always @(negedge clk) begin
        if (load) begin
            n_loads = n_loads + 1;
            ld_hh   = set_hh;
            ld_mm   = set_mm;
            ld_ss   = set_ss;
            ld_pm   = set_pm;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        @(posedge clk); #1;
        key_mode = m;
        key_inc  = i;
        key_dec  = d;
        repeat (D + 4) @(posedge clk);
        #1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic p);
        cur_hh = h;
        cur_mm = m;
        cur_ss = s;
        cur_pm = p;
    endtask

    initial begin
        reset    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        set_cur(8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hh", set_hh, 8'h12);
        chk("rst_mm", set_mm, 8'h00);
        chk("rst_ss", set_ss, 8'h00);
        chk("rst_pm", set_pm, 1'b0);
        chk("rst_load", load, 1'b0);
        chk("rst_active", set_active, 1'b0);
        chk("rst_field", field, 2'd0);

        // Mode press latency and hour wrap
        set_cur(8'h11, 8'h59, 8'h58, 1'b1);
        @(posedge clk); #1;
        key_mode = 1'b1;
        repeat (D + 3) @(posedge clk);
        #1;
        chk("lat_before", set_active, 1'b0);
        @(posedge clk); #1;
        chk("lat_active", set_active, 1'b1);
        chk("lat_hh", set_hh, 8'h11);
        chk("lat_field", field, 2'd0);
        key_mode = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
        press(1'b0, 1'b1, 1'b0);
        chk("hh_inc1", set_hh, 8'h12);
        press(1'b0, 1'b1, 1'b0);
        chk("hh_inc2", set_hh, 8'h01);
        press(1'b0, 1'b0, 1'b1);
        chk("hh_dec", set_hh, 8'h12);
        chk("still_active", set_active, 1'b1);
        repeat (T + 4) @(posedge clk);
        #1;
        chk("to_active", set_active, 1'b0);
        chk("to_field", field, 2'd0);
        chk("to_noload", n_loads, 0);
        chk("to_keep_hh", set_hh, 8'h12);
        chk("to_keep_mm", set_mm, 8'h59);

        // Full edit and commit
        set_cur(8'h12, 8'h00, 8'h00, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("fe_hh", set_hh, 8'h12);
        press(1'b1, 1'b0, 1'b0);
        chk("fe_field_mm", field, 2'd1);
        press(1'b0, 1'b0, 1'b1);
        chk("fe_mm_dec", set_mm, 8'h59);
        press(1'b1, 1'b0, 1'b0);
        chk("fe_field_ss", field, 2'd2);
        for (int n = 0; n < 9; n++)
            press(1'b0, 1'b1, 1'b0);
        chk("fe_ss9", set_ss, 8'h09);
        press(1'b0, 1'b1, 1'b0);
        chk("fe_ss10", set_ss, 8'h10);
        press(1'b1, 1'b0, 1'b0);
        chk("fe_field_pm", field, 2'd3);
        press(1'b0, 1'b1, 1'b0);
        chk("fe_pm", set_pm, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk("cm_loads", n_loads, 1);
        chk("cm_hh", ld_hh, 8'h12);
        chk("cm_mm", ld_mm, 8'h59);
        chk("cm_ss", ld_ss, 8'h10);
        chk("cm_pm", ld_pm, 1'b1);
        chk("cm_idle", set_active, 1'b0);
        chk("cm_hold_ss", set_ss, 8'h10);

        // Short pulse and bounce train
        set_cur(8'h05, 8'h30, 8'h15, 1'b0);
        @(posedge clk); #1;
        key_mode = 1'b1;
        repeat (D - 1) @(posedge clk);
        #1 key_mode = 1'b0;
        repeat (D + 6) @(posedge clk);
        #1;
        chk("glitch", set_active, 1'b0);
        for (int n = 0; n < 3; n++) begin
            key_mode = 1'b1;
            repeat (2) @(posedge clk);
            #1 key_mode = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        key_mode = 1'b1;
        repeat (D + 4) @(posedge clk);
        #1;
        chk("bounce_active", set_active, 1'b1);
        chk("bounce_once", field, 2'd0);
        key_mode = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;

        // Same-cycle events
        press(1'b0, 1'b1, 1'b1);
        chk("incdec_hh", set_hh, 8'h05);
        press(1'b1, 1'b1, 1'b0);
        chk("modeinc_field", field, 2'd1);
        chk("modeinc_hh", set_hh, 8'h05);
        repeat (T + 4) @(posedge clk);
        #1;
        press(1'b0, 1'b1, 1'b0);
        chk("idle_inc", set_hh, 8'h05);

        // Invalid capture normalisation
        set_cur(8'h00, 8'h75, 8'h5A, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("inv_hh", set_hh, 8'h12);
        chk("inv_mm", set_mm, 8'h00);
        chk("inv_ss", set_ss, 8'h00);
        repeat (T + 4) @(posedge clk);
        #1;

        // Reset mid-edit
        set_cur(8'h03, 8'h45, 8'h30, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk("re_hh", set_hh, 8'h03);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("re_rst_hh", set_hh, 8'h12);
        chk("re_rst_mm", set_mm, 8'h00);
        chk("re_rst_ss", set_ss, 8'h00);
        chk("re_rst_pm", set_pm, 1'b0);
        chk("re_rst_act", set_active, 1'b0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("total_loads", n_loads, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
